// File: rtl/seg_pkg.sv
// seg_pkg: shared segment encodings and BCD decode for the front-panel display
package seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [15:0][6:0] SEG_MAP = {
    {6{SEG_DASH}},
    7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
    7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    return SEG_MAP[bcd];
  endfunction
endpackage

// File: rtl/bcd7seg.sv
// bcd7seg: combinational BCD to active-low seven-segment decoder, dash for non-BCD
module bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = bcd_to_seg(bcd);
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed N-digit seven-segment scanner with double buffering, leading-zero blanking and blink
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
  logic [FW-1:0] frm_q, frm_d;
  logic phase_q, phase_d, wrap_q, wrap_d, fd_q, fd_d;
  logic [6:0] seg_q, seg_d, dec;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic tick, frm_last, lz;
  logic [3:0] cur;
  bcd7seg u_dec (.bcd(cur), .seg(dec));
  always_comb begin
    tick = pre_q == PW'(SCAN_DIV - 1);
    wrap_d = tick && idx_q == IW'(NUM_DIGITS - 1);
    pre_d = tick ? '0 : pre_q + PW'(1);
    idx_d = wrap_d ? '0 : idx_q + IW'(tick);
    shadow_d = load ? digits : shadow_q;
    disp_d = wrap_d ? shadow_d : disp_q;
    frm_last = frm_q == FW'(BLINK_FRAMES - 1);
    frm_d = !blink_en ? '0 : wrap_d ? (frm_last ? '0 : frm_q + FW'(1)) : frm_q;
    phase_d = blink_en && (phase_q ^ (wrap_d && frm_last));
    cur = disp_q[4*idx_q +: 4];
    lz = blank_lz && idx_q != '0 && (disp_q >> {idx_q, 2'b00}) == '0;
    an_d = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = (lz || (blink_en && phase_q)) ? SEG_BLANK : dec;
    fd_d = wrap_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
      shadow_q <= '0;
      disp_q <= '0;
      frm_q <= '0;
      phase_q <= 1'b0;
      wrap_q <= 1'b0;
      seg_q <= SEG_BLANK;
      an_q <= '1;
      fd_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      disp_q <= disp_d;
      frm_q <= frm_d;
      phase_q <= phase_d;
      wrap_q <= wrap_d;
      seg_q <= seg_d;
      an_q <= an_d;
      fd_q <= fd_d;
    end
  end
  assign seg = seg_q;
  assign an = an_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver with directed panel checks
module tb_seg_scan_driver;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0, blank_lz = 1'b0, blink_en = 1'b0;
  logic [11:0] digits = '0;
  logic [6:0] seg;
  logic [2:0] an;
  logic frame_done;
  int errors = 0, checks = 0;
  logic [10:0] sb [$];
  logic [6:0] tbl [16];
  int m_pre = 0, m_idx = 0, m_frm = 0;
  logic [11:0] m_disp = '0, m_sh = '0;
  logic m_ph = 1'b0, m_wr = 1'b0;
  seg_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .digits(digits), .load(load), .blank_lz(blank_lz),
    .blink_en(blink_en), .seg(seg), .an(an), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    logic [6:0] es;
    logic [3:0] d;
    logic lz, wrap;
    if (reset) begin
      m_pre = 0; m_idx = 0; m_frm = 0; m_disp = '0; m_sh = '0; m_ph = 1'b0; m_wr = 1'b0;
      sb.push_back({7'b1111111, 3'b111, 1'b0});
    end else begin
      d = m_disp[m_idx*4 +: 4];
      lz = blank_lz && m_idx != 0;
      for (int j = m_idx; j < 3; j++) if (m_disp[j*4 +: 4] != 4'd0) lz = 1'b0;
      es = (lz || (blink_en && m_ph)) ? 7'b1111111 : tbl[d];
      sb.push_back({es, ~(3'b001 << m_idx), m_wr});
      wrap = m_pre == 3 && m_idx == 2;
      if (wrap) m_disp = load ? digits : m_sh;
      if (load) m_sh = digits;
      m_wr = wrap;
      if (!blink_en) begin
        m_frm = 0;
        m_ph = 1'b0;
      end else if (wrap) begin
        m_frm++;
        if (m_frm == 2) begin
          m_frm = 0;
          m_ph = !m_ph;
        end
      end
      if (m_pre == 3) m_idx = (m_idx + 1) % 3;
      m_pre = (m_pre + 1) % 4;
    end
  end
  always @(negedge clk) begin
    logic [10:0] e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("sb_seg", seg, e[10:4]);
      check("sb_an", an, e[3:1]);
      check("sb_frame_done", frame_done, e[0]);
    end
  end
  task automatic do_load(input logic [11:0] v);
    digits = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic grab(input string tag, input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
    logic [6:0] e [3];
    logic [2:0] ea;
    int n;
    e = '{e0, e1, e2};
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sync"}, n < 40, 1);
    for (int k = 0; k < 3; k++) begin
      ea = ~(3'b001 << k);
      check($sformatf("%s_an%0d", tag, k), an, ea);
      check($sformatf("%s_d%0d", tag, k), seg, e[k]);
      if (k < 2) repeat (4) @(negedge clk);
    end
  endtask
  initial begin
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
            7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
    repeat (3) @(negedge clk);
    check("reset_seg", seg, 7'b1111111);
    check("reset_an", an, 3'b111);
    check("reset_fd", frame_done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("first_an", an, 3'b110);
    check("first_seg", seg, 7'b0000001);
    do_load(12'h125);
    grab("f125", 7'b0100100, 7'b0010010, 7'b1001111);
    grab("f125b", 7'b0100100, 7'b0010010, 7'b1001111);
    blank_lz = 1'b1;
    do_load(12'h005);
    grab("lz005", 7'b0100100, 7'b1111111, 7'b1111111);
    do_load(12'h000);
    grab("lz000", 7'b0000001, 7'b1111111, 7'b1111111);
    do_load(12'h050);
    grab("lz050", 7'b0000001, 7'b0100100, 7'b1111111);
    do_load(12'hA05);
    grab("lzA05", 7'b0100100, 7'b0000001, 7'b1111110);
    blank_lz = 1'b0;
    do_load(12'h3A7);
    grab("mid_dash", 7'b0001111, 7'b1111110, 7'b0000110);
    repeat (2) @(negedge clk);
    do_load(12'h999);
    grab("wrap_load", 7'b0000100, 7'b0000100, 7'b0000100);
    do_load(12'h125);
    check("midload_keep", seg, 7'b0000100);
    grab("midload_new", 7'b0100100, 7'b0010010, 7'b1001111);
    blink_en = 1'b1;
    repeat (60) @(negedge clk);
    blink_en = 1'b0;
    repeat (14) @(negedge clk);
    blank_lz = 1'b1;
    do_load(12'h042);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_seg", seg, 7'b1111111);
    check("midreset_an", an, 3'b111);
    check("midreset_fd", frame_done, 0);
    reset = 1'b0;
    blank_lz = 1'b0;
    grab("post_reset", 7'b0000001, 7'b0000001, 7'b0000001);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
